// File: rtl/output_buffer_pkg.sv
// Shared types and helpers for the output-side pixel stream stages.
package output_buffer_pkg;

  localparam int AXIS_TDATA_WIDTH = 32;
  localparam int PIX_W            = 8;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    rgb_t pix;
    logic last;
  } beat_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  // Byte order R/G/B/0 must match the input-side unpack.
  function automatic logic [AXIS_TDATA_WIDTH-1:0] pack_rgba(input rgb_t p);
    return {p.r, p.g, p.b, 8'h00};
  endfunction

endpackage

// File: rtl/output_buffer_if.sv
// AXI-Stream bus carrying packed RGB pixels out of the output buffer.
interface output_buffer_if #(
  parameter int TDATA_W = 32
);
  logic                   m_tvalid;
  logic                   m_tready;
  logic [TDATA_W-1:0]     m_tdata;
  logic [TDATA_W/8-1:0]   m_tstrb;
  logic                   m_tlast;

  modport master (output m_tvalid, output m_tdata, output m_tstrb, output m_tlast, input m_tready);
  modport slave  (input m_tvalid, input m_tdata, input m_tstrb, input m_tlast, output m_tready);
endinterface

// File: rtl/output_buffer_axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
module axis_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_s, push_s;

  assign valid_o = (count_q != CNT_W'(0));
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign pop_s   = pop_i && valid_o;
  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign push_s  = push_i && (!full_o || pop_s);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH-1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH-1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
      end
      if (push_s && !pop_s) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop_s && !push_s) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/output_buffer_checker.sv
// Protocol checks for the output buffer; holds no design state.
module output_buffer_checker (
  input logic clk_i,
  input logic rst_i,
  input logic push_i,
  input logic full_i,
  input logic pop_i
);
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_i && !pop_i))
    else $error("output_buffer: pixel pushed into full FIFO and dropped");
endmodule

// File: rtl/output_buffer.sv
// Tags useful pixels of each column, queues them and streams them out over AXI-S,
// throttling the upstream input buffer and flagging frame completion.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int DATA_WIDTH         = 8,
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int INPUT_HEIGHT       = 480,
  parameter int PAD_CYCLES         = 3,
  parameter int VALID_OFFSET       = 3,
  parameter int PIPE_LATENCY       = 1,
  parameter int OUT_COLUMNS        = 640,
  parameter int FIFO_DEPTH         = 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] in_R,
  input  logic [DATA_WIDTH-1:0] in_G,
  input  logic [DATA_WIDTH-1:0] in_B,
  input  logic                  data_flowing,
  input  logic                  is_full_columns_first_input,
  output logic                  output_has_back_pressure,
  output logic                  output_buffer_is_done,
  output_buffer_if.master       m_axis
);
  localparam int PH_W     = $clog2(INPUT_HEIGHT + PAD_CYCLES + 1) + 1;
  localparam int COL_W    = (OUT_COLUMNS > 1) ? $clog2(OUT_COLUMNS) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int LAST_PH  = VALID_OFFSET + INPUT_HEIGHT - 1;

  logic [PH_W-1:0]  phase_q, phase_d, cur_phase_s;
  logic [COL_W-1:0] col_q, col_d;
  logic             active_q, active_d, cur_active_s;
  logic             row_last_s, col_end_s;
  tag_t             gen_tag_s, exit_tag_s;
  logic             done_q;
  logic             push_s, hs_s, full_s;
  logic [CNT_W-1:0] count_s;
  beat_t            push_beat_s, pop_beat_s;

  // Tag for the current flow cycle: a marker makes this cycle phase 0 of a new column.
  always_comb begin
    cur_active_s = active_q;
    cur_phase_s  = phase_q;
    if (is_full_columns_first_input) begin
      cur_active_s = 1'b1;
      cur_phase_s  = '0;
    end else begin
      cur_active_s = active_q;
      cur_phase_s  = phase_q + PH_W'(1);
    end
    gen_tag_s.valid = cur_active_s && (cur_phase_s >= PH_W'(VALID_OFFSET))
                      && (cur_phase_s <= PH_W'(LAST_PH));
    row_last_s      = (cur_phase_s == PH_W'(LAST_PH));
    col_end_s       = gen_tag_s.valid && row_last_s;
    gen_tag_s.last  = col_end_s && (col_q == COL_W'(OUT_COLUMNS-1));
  end

  // Column state next-state: advances only on flow cycles.
  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    col_d    = col_q;
    if (data_flowing) begin
      phase_d  = cur_active_s ? cur_phase_s : phase_q;
      active_d = cur_active_s && !col_end_s;
      if (col_end_s) begin
        col_d = (col_q == COL_W'(OUT_COLUMNS-1)) ? COL_W'(0) : col_q + COL_W'(1);
      end else begin
        col_d = col_q;
      end
    end else begin
      phase_d  = phase_q;
      active_d = active_q;
      col_d    = col_q;
    end
  end

  // Column state registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      phase_q  <= '0;
      active_q <= 1'b0;
      col_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      col_q    <= col_d;
    end
  end

  if (PIPE_LATENCY == 0) begin : g_no_pipe
    assign exit_tag_s = gen_tag_s;
  end else begin : g_pipe
    tag_t pipe_q [PIPE_LATENCY];
    // Tags travel alongside the processing block's data, stalling with it.
    always_ff @(posedge aclk) begin
      if (areset) begin
        for (int i = 0; i < PIPE_LATENCY; i++) pipe_q[i] <= '0;
      end else if (data_flowing) begin
        pipe_q[0] <= gen_tag_s;
        for (int i = 1; i < PIPE_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign exit_tag_s = pipe_q[PIPE_LATENCY-1];
  end

  assign push_s           = data_flowing && exit_tag_s.valid;
  assign push_beat_s.pix  = '{r: in_R, g: in_G, b: in_B};
  assign push_beat_s.last = exit_tag_s.last;
  assign hs_s             = m_axis.m_tvalid && m_axis.m_tready;

  axis_sync_fifo #(.WIDTH($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (push_s),
    .data_i  (push_beat_s),
    .pop_i   (m_axis.m_tready),
    .data_o  (pop_beat_s),
    .valid_o (m_axis.m_tvalid),
    .full_o  (full_s),
    .count_o (count_s)
  );

  assign m_axis.m_tdata  = pack_rgba(pop_beat_s.pix);
  assign m_axis.m_tlast  = pop_beat_s.last;
  assign m_axis.m_tstrb  = {(C_AXIS_TDATA_WIDTH/8){1'b1}};
  assign output_has_back_pressure = (count_s == CNT_W'(FIFO_DEPTH)) && !hs_s;
  assign output_buffer_is_done    = done_q;

  // Sticky frame-done flag; a new column marker rearms it (clear beats set).
  always_ff @(posedge aclk) begin
    if (areset) begin
      done_q <= 1'b0;
    end else if (data_flowing && is_full_columns_first_input) begin
      done_q <= 1'b0;
    end else if (hs_s && pop_beat_s.last) begin
      done_q <= 1'b1;
    end
  end

  output_buffer_checker u_checker (
    .clk_i  (aclk),
    .rst_i  (areset),
    .push_i (push_s),
    .full_i (full_s),
    .pop_i  (hs_s)
  );

endmodule

// File: tb/tb_output_buffer.sv
// Randomized self-checking bench for output_buffer against a frame-level reference model.
module tb_output_buffer;

  localparam int IH     = 4;
  localparam int PAD    = 3;
  localparam int VO     = 3;
  localparam int PL     = 2;
  localparam int OC     = 2;
  localparam int DEPTH  = 2;
  localparam int COLLEN = IH + PAD;

  logic       aclk = 1'b0;
  logic       areset;
  logic [7:0] in_R, in_G, in_B;
  logic       data_flowing, marker;
  logic       bp, done;

  output_buffer_if #(.TDATA_W(32)) m_axis ();

  output_buffer #(
    .DATA_WIDTH(8), .C_AXIS_TDATA_WIDTH(32), .INPUT_HEIGHT(IH), .PAD_CYCLES(PAD),
    .VALID_OFFSET(VO), .PIPE_LATENCY(PL), .OUT_COLUMNS(OC), .FIFO_DEPTH(DEPTH)
  ) dut (
    .aclk                        (aclk),
    .areset                      (areset),
    .in_R                        (in_R),
    .in_G                        (in_G),
    .in_B                        (in_B),
    .data_flowing                (data_flowing),
    .is_full_columns_first_input (marker),
    .output_has_back_pressure    (bp),
    .output_buffer_is_done       (done),
    .m_axis                      (m_axis)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit         marker;
    bit         valid;
    bit         last;
    logic [7:0] r, g, b;
  } slot_t;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } beat_exp_t;

  slot_t     stream_q[$];
  beat_exp_t exp_q[$];
  int        n_checks = 0;
  int        n_pass   = 0;
  int        model_cnt = 0;
  bit        exp_done = 1'b0;
  int        bp_seen;
  bit        reset_hit;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One column of n flow cycles; valid rows sit at phases VO..VO+IH-1.
  task automatic add_col(input int n, input int col, input int mode);
    for (int p = 0; p < n; p++) begin
      slot_t s;
      s.marker = (p == 0);
      s.valid  = (p >= VO) && (p < VO + IH);
      s.last   = s.valid && (p == VO + IH - 1) && (col == OC - 1);
      case (mode)
        1:       begin s.r = 8'(p); s.g = 8'(8'hA0 + p); s.b = 8'(col); end
        2:       begin s.r = 8'h11; s.g = 8'h22; s.b = 8'h33; end
        default: begin s.r = 8'($urandom); s.g = 8'($urandom); s.b = 8'($urandom); end
      endcase
      stream_q.push_back(s);
    end
  endtask

  task automatic add_frame(input int mode, input bit restart);
    if (restart) add_col(5, 0, mode);
    add_col(COLLEN, 0, mode);
    add_col(COLLEN, 1, mode);
    for (int i = 0; i < PL; i++) begin
      slot_t s;
      s.marker = 1'b0; s.valid = 1'b0; s.last = 1'b0;
      s.r = 8'($urandom); s.g = 8'($urandom); s.b = 8'($urandom);
      stream_q.push_back(s);
    end
  endtask

  // A pixel presented on flow cycle k belongs to the tag generated PL flow cycles earlier.
  task automatic build_expected();
    exp_q.delete();
    for (int k = PL; k < stream_q.size(); k++) begin
      if (stream_q[k-PL].valid) begin
        beat_exp_t e;
        e.data = {stream_q[k].r, stream_q[k].g, stream_q[k].b, 8'h00};
        e.last = stream_q[k-PL].last;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_idle_after_reset(input string tag);
    check_eq({tag, "_tvalid"}, m_axis.m_tvalid, 0);
    check_eq({tag, "_tdata"},  m_axis.m_tdata, 0);
    check_eq({tag, "_tlast"},  m_axis.m_tlast, 0);
    check_eq({tag, "_bp"},     bp, 0);
    check_eq({tag, "_done"},   done, 0);
  endtask

  task automatic run_stream(input int fmode, input int tmode, input bit do_reset);
    int k = 0;
    int cyc = 0;
    bit want, flow, hs, push, mk;
    build_expected();
    while ((k < stream_q.size() || exp_q.size() != 0) && cyc < 4000) begin
      @(negedge aclk);
      cyc++;
      case (tmode)
        1:       m_axis.m_tready = 1'($urandom_range(0, 1));
        2:       m_axis.m_tready = (cyc > 40);
        default: m_axis.m_tready = 1'b1;
      endcase
      #1;
      if (do_reset && model_cnt == 1 && k >= 12) begin
        data_flowing = 1'b0; marker = 1'b0; m_axis.m_tready = 1'b0; areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        #2;
        check_idle_after_reset("midreset");
        model_cnt = 0; exp_done = 1'b0; reset_hit = 1'b1;
        stream_q.delete(); exp_q.delete();
        return;
      end
      want = (fmode == 0) ? 1'b1 : (cyc % 3 == 0);
      flow = want && !bp && (k < stream_q.size());
      if (bp) bp_seen++;
      if (flow) begin
        data_flowing = 1'b1; marker = stream_q[k].marker;
        in_R = stream_q[k].r; in_G = stream_q[k].g; in_B = stream_q[k].b;
      end else begin
        data_flowing = 1'b0; marker = 1'($urandom_range(0, 1));
        in_R = 8'($urandom); in_G = 8'($urandom); in_B = 8'($urandom);
      end
      #1;
      check_eq("m_tvalid", m_axis.m_tvalid, model_cnt != 0);
      check_eq("back_pressure", bp, (model_cnt == DEPTH) && !m_axis.m_tready);
      check_eq("done", done, exp_done);
      if (model_cnt != 0) begin
        check_eq("m_tdata", m_axis.m_tdata, exp_q[0].data);
        check_eq("m_tlast", m_axis.m_tlast, exp_q[0].last);
        check_eq("m_tstrb", m_axis.m_tstrb, 4'hF);
      end
      hs   = (model_cnt != 0) && m_axis.m_tready;
      push = flow && (k >= PL) && stream_q[k-PL].valid;
      mk   = flow && stream_q[k].marker;
      if (mk) exp_done = 1'b0;
      else if (hs && exp_q[0].last) exp_done = 1'b1;
      if (hs) void'(exp_q.pop_front());
      if (flow) k++;
      model_cnt = model_cnt + int'(push) - int'(hs);
    end
    check_eq("stream_consumed", k, stream_q.size());
    check_eq("beats_drained", exp_q.size(), 0);
    stream_q.delete();
    @(negedge aclk);
    data_flowing = 1'b0; marker = 1'b0;
    #2;
    check_eq("done_after_frame", done, 1);
    check_eq("tvalid_after_frame", m_axis.m_tvalid, 0);
  endtask

  initial begin
    areset = 1'b1; data_flowing = 1'b0; marker = 1'b0;
    in_R = 8'h00; in_G = 8'h00; in_B = 8'h00; m_axis.m_tready = 1'b0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    #2;
    check_idle_after_reset("reset");

    // in_R = phase, continuous flow, always ready
    add_frame(1, 1'b0);
    run_stream(0, 0, 1'b0);
    // fixed 0x11/0x22/0x33 pixel packing
    add_frame(2, 1'b0);
    run_stream(0, 0, 1'b0);
    // ready held low at start: FIFO fills and throttles upstream
    bp_seen = 0;
    add_frame(0, 1'b0);
    run_stream(0, 2, 1'b0);
    check_eq("bp_seen", bp_seen > 0, 1);
    // 1-on/2-off flow gaps
    add_frame(1, 1'b0);
    run_stream(1, 0, 1'b0);
    // marker re-asserted mid-column, random ready
    add_frame(0, 1'b1);
    run_stream(0, 1, 1'b0);
    // random gaps and ready
    add_frame(0, 1'b0);
    run_stream(1, 1, 1'b0);
    // reset pulsed mid-column with one queued entry
    reset_hit = 1'b0;
    add_frame(0, 1'b0);
    run_stream(0, 0, 1'b1);
    check_eq("reset_hit", reset_hit, 1);
    // clean frame after reset
    add_frame(0, 1'b0);
    run_stream(0, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
